seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor for the Tiny-CPU datapath, replacing the fixed 8-bit combinational adder wherever a registered, flag-producing arithmetic unit is required. The block latches two WIDTH-bit operands on a start pulse and resolves the carry chain CHUNK bits per clock, LSB chunk first. On completion it presents a registered result with carry, overflow, zero and negative flags and a one-cycle done pulse. It sits between the register file and the ALU result mux.

---
 rtl/seq_addsub_if.sv | 26 ++
 rtl/seq_addsub.sv | 117 +++++++++++
 tb/tb_seq_addsub.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// rtl/seq_addsub_if.sv - operand/result bundle between the register file side and seq_addsub
interface seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry_out, overflow, zero, negative
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle adder/subtractor resolving CHUNK bits per clock, LSB first
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_chunk_hi;
  logic [WIDTH-1:0] w_next_sum;
  logic             w_last;
  logic             w_overflow;

  // Operands shift right each RUN cycle so the active chunk is always at bit 0;
  // finished sum chunks enter from the top and land in place after N cycles.
  assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_chunk_hi  = WIDTH'(w_chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK);
  assign w_next_sum  = (r_sum >> CHUNK) | w_chunk_hi;
  assign w_last      = (r_k == KW'(N - 1));
  assign w_overflow  = (r_a_msb == r_b_msb) && (w_next_sum[WIDTH-1] != r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_negative  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
            r_a_msb <= bus.op_a[WIDTH-1];
            r_b_msb <= bus.sub ? ~bus.op_b[WIDTH-1] : bus.op_b[WIDTH-1];
            r_carry <= bus.sub;
            r_sum   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_next_sum;
          r_carry <= w_chunk_sum[CHUNK];
          r_k     <= r_k + KW'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_result    <= w_next_sum;
            r_carry_out <= w_chunk_sum[CHUNK];
            r_overflow  <= w_overflow;
            r_zero      <= (w_next_sum == '0);
            r_negative  <= w_next_sum[WIDTH-1];
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - directed and swept checks of seq_addsub at CHUNK = 4, 8 and 2
module tb_seq_addsub;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_addsub_if #(.WIDTH(8)) m4 ();
  seq_addsub_if #(.WIDTH(8)) m8 ();
  seq_addsub_if #(.WIDTH(8)) m2 ();

  seq_addsub #(.WIDTH(8), .CHUNK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));
  seq_addsub #(.WIDTH(8), .CHUNK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(m8));
  seq_addsub #(.WIDTH(8), .CHUNK(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_calc(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] bb;
    logic [8:0] full;
    logic [7:0] r;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    r    = full[7:0];
    return {r, full[8], (a[7] == bb[7]) && (r[7] != a[7]), (r == 8'd0), r[7]};
  endfunction

  // Ends on the falling edge of the done cycle; lat is -1 if done never came.
  task automatic run_main(input logic s, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_err);
    @(negedge clk);
    m4.start = 1'b1; m4.sub = s; m4.op_a = a; m4.op_b = b;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b0; m4.sub = ~s; m4.op_a = ~a; m4.op_b = ~b;
    lat = -1;
    busy_err = 0;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (m4.done) begin
        lat = c;
        if (m4.busy) busy_err++;
      end else if (!m4.busy) begin
        busy_err++;
      end
    end
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic ec, input logic ev, input logic ez, input logic en);
    int lat;
    int be;
    run_main(s, a, b, lat, be);
    check_eq({tag, "_lat"}, lat, 2);
    check_eq({tag, "_busy"}, be, 0);
    check_eq({tag, "_res"}, m4.result, er);
    check_eq({tag, "_c"}, m4.carry_out, ec);
    check_eq({tag, "_v"}, m4.overflow, ev);
    check_eq({tag, "_z"}, m4.zero, ez);
    check_eq({tag, "_n"}, m4.negative, en);
  endtask

  task automatic sweep_op(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [11:0] e;
    int l8;
    int l2;
    e = ref_calc(s, a, b);
    @(negedge clk);
    m8.start = 1'b1; m8.sub = s; m8.op_a = a; m8.op_b = b;
    m2.start = 1'b1; m2.sub = s; m2.op_a = a; m2.op_b = b;
    @(posedge clk);
    @(negedge clk);
    m8.start = 1'b0; m8.op_a = b; m8.op_b = a;
    m2.start = 1'b0; m2.op_a = b; m2.op_b = a;
    l8 = -1;
    l2 = -1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (m8.done && l8 < 0) begin
        l8 = c;
        check_eq("sweep8_out", {m8.result, m8.carry_out, m8.overflow, m8.zero, m8.negative}, e);
      end
      if (m2.done && l2 < 0) begin
        l2 = c;
        check_eq("sweep2_out", {m2.result, m2.carry_out, m2.overflow, m2.zero, m2.negative}, e);
      end
    end
    check_eq("sweep8_lat", l8, 1);
    check_eq("sweep2_lat", l2, 4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int be;
    int pulses;
    checks = 0;
    failures = 0;
    m4.start = 1'b0; m4.sub = 1'b0; m4.op_a = '0; m4.op_b = '0;
    m8.start = 1'b0; m8.sub = 1'b0; m8.op_a = '0; m8.op_b = '0;
    m2.start = 1'b0; m2.sub = 1'b0; m2.op_a = '0; m2.op_b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", m4.busy, 0);
    check_eq("rst_done", m4.done, 0);
    check_eq("rst_flags", {m4.result, m4.carry_out, m4.overflow, m4.zero, m4.negative}, 12'h002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    directed("add",    1'b0, 8'h3C, 8'h0A, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("ovf",    1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    directed("wrap",   1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("sub_neg",1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    directed("sub_ovf",1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    directed("sub_eq", 1'b1, 8'h42, 8'h42, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // start during RUN must be ignored
    @(negedge clk);
    m4.start = 1'b1; m4.sub = 1'b0; m4.op_a = 8'h3C; m4.op_b = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b1; m4.sub = 1'b1; m4.op_a = 8'h01; m4.op_b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b0;
    check_eq("ign_busy1", m4.busy, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("ign_done", m4.done, 1);
    check_eq("ign_res", m4.result, 8'h46);
    @(posedge clk);
    @(negedge clk);
    check_eq("ign_idle", {m4.busy, m4.done}, 2'b00);

    // back-to-back: start held in the DONE cycle
    pulses = 0;
    @(negedge clk);
    m4.start = 1'b1; m4.sub = 1'b0; m4.op_a = 8'h10; m4.op_b = 8'h20;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b0;
    check_eq("b2b_busy0", {m4.busy, m4.done}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_busy1", {m4.busy, m4.done}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    if (m4.done) pulses++;
    check_eq("b2b_done1", {m4.busy, m4.done}, 2'b01);
    check_eq("b2b_res1", m4.result, 8'h30);
    m4.start = 1'b1; m4.sub = 1'b0; m4.op_a = 8'h50; m4.op_b = 8'h25;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b0;
    check_eq("b2b_run2a", {m4.busy, m4.done}, 2'b10);
    check_eq("b2b_hold_a", m4.result, 8'h30);
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_run2b", {m4.busy, m4.done}, 2'b10);
    check_eq("b2b_hold_b", m4.result, 8'h30);
    @(posedge clk);
    @(negedge clk);
    if (m4.done) pulses++;
    check_eq("b2b_done2", {m4.busy, m4.done}, 2'b01);
    check_eq("b2b_res2", m4.result, 8'h75);
    check_eq("b2b_pulses", pulses, 2);

    // reset in the first RUN cycle
    @(negedge clk);
    m4.start = 1'b1; m4.sub = 1'b0; m4.op_a = 8'h11; m4.op_b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    m4.start = 1'b0;
    check_eq("rr_busy_pre", m4.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rr_state", {m4.busy, m4.done}, 2'b00);
    check_eq("rr_flags", {m4.result, m4.carry_out, m4.overflow, m4.zero, m4.negative}, 12'h002);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (m4.done || m4.busy) pulses++;
    end
    check_eq("rr_no_done", pulses, 0);
    directed("rr_again", 1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    sweep_op(1'b0, 8'hFF, 8'h01);
    sweep_op(1'b1, 8'h80, 8'h01);
    for (int i = 0; i < 1000; i++) begin
      sweep_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
